// File: rtl/pipeline_clk_pkg.sv
// pipeline_clk_pkg: shared CPU-clock constants, kept in step with the clock divider
//   DEF_DIV_HALF : sysclk cycles per CPU-clock half period
//   DEF_DW       : CPU write data width
//   PERIOD_NOM   : nominal CPU period in sysclk cycles
//   TIMEOUT      : sysclk cycles without a CPU rise that count as a stopped clock
package pipeline_clk_pkg;

    localparam int DEF_DIV_HALF = 9;
    localparam int DEF_DW       = 32;

    function automatic int period_nom(input int dh);
        return 2 * dh;
    endfunction

    function automatic int timeout(input int dh);
        return 4 * dh;
    endfunction

    localparam int PERIOD_NOM = period_nom(DEF_DIV_HALF);
    localparam int TIMEOUT    = timeout(DEF_DIV_HALF);

endpackage

// File: rtl/pipeline_clk_fifo.sv
// pipeline_clk_fifo: synchronous first-word-fall-through FIFO on sysclk
//   sysclk, reset : clock, asynchronous active-high reset (empties the FIFO)
//   i_push        : write i_push_data; accepted when not full or when popping
//   i_pop         : advance the head; ignored while empty
//   o_head        : current head entry
//   o_empty       : no entries held
//   o_full        : DEPTH entries held
module pipeline_clk_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic          sysclk,
    input  logic          reset,
    input  logic          i_push,
    input  logic [DW-1:0] i_push_data,
    input  logic          i_pop,
    output logic [DW-1:0] o_head,
    output logic          o_empty,
    output logic          o_full
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]   r_wptr;
    logic [AW:0]   r_rptr;
    logic [DW-1:0] r_mem [DEPTH];
    logic          w_pop;
    logic          w_push;

    assign o_empty = r_wptr == r_rptr;
    // Extra pointer bit tells full from empty: same slot, opposite lap.
    assign o_full  = (r_wptr ^ r_rptr) == {1'b1, {AW{1'b0}}};
    assign o_head  = r_mem[r_rptr[AW-1:0]];
    assign w_pop   = i_pop & ~o_empty;
    // When full, a simultaneous pop frees the head slot that this write reuses.
    assign w_push  = i_push & (~o_full | w_pop);

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr[AW-1:0]] <= i_push_data;
                r_wptr                <= r_wptr + 1'b1;
            end
            if (w_pop) r_rptr <= r_rptr + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_clk_bridge.sv
// pipeline_clk_bridge: sysclk-domain receiver for the divided CPU clock and CPU writes
//   sysclk, reset        : 100 MHz clock, asynchronous active-high reset
//   i_cpu_clk            : divided CPU clock, sampled as data
//   i_cpu_wr_en/_data    : CPU write, launched at CPU rise, held one CPU cycle
//   o_out_valid/_data    : FWFT FIFO head towards the consumer
//   i_out_ready          : consumer accepts the head
//   o_cpu_rise/_fall     : one-cycle strobes per synchronized CPU edge
//   o_overflow           : sticky, a write was dropped on a full FIFO
//   o_period_err         : sticky, wrong CPU period or stopped CPU clock
//   i_clr_err            : synchronous clear of both sticky flags
module pipeline_clk_bridge
    import pipeline_clk_pkg::*;
#(
    parameter int DIV_HALF = DEF_DIV_HALF,
    parameter int DW       = DEF_DW,
    parameter int DEPTH    = 4
) (
    input  logic          sysclk,
    input  logic          reset,
    input  logic          i_cpu_clk,
    input  logic          i_cpu_wr_en,
    input  logic [DW-1:0] i_cpu_wr_data,
    output logic          o_out_valid,
    output logic [DW-1:0] o_out_data,
    input  logic          i_out_ready,
    output logic          o_cpu_rise,
    output logic          o_cpu_fall,
    output logic          o_overflow,
    output logic          o_period_err,
    input  logic          i_clr_err
);

    localparam int            PW     = $clog2(timeout(DIV_HALF) + 1);
    localparam logic [PW-1:0] P_LAST = PW'(period_nom(DIV_HALF) - 1);
    localparam logic [PW-1:0] P_TO   = PW'(timeout(DIV_HALF));

    logic          r_sync1;
    logic          r_sync2;
    logic          r_hist;
    logic          r_rise;
    logic          r_fall;
    logic [PW-1:0] r_pcnt;
    logic          r_armed;
    logic          r_ovf;
    logic          r_perr;
    logic [PW-1:0] w_pcnt_nxt;
    logic          w_push;
    logic          w_pop;
    logic          w_empty;
    logic          w_full;
    logic          w_ovf_set;
    logic          w_perr_set;

    // Writes are taken on the fall strobe, mid CPU cycle, when wr_en/data are settled.
    assign w_push      = r_fall & i_cpu_wr_en;
    assign w_pop       = ~w_empty & i_out_ready;
    assign w_ovf_set   = w_push & w_full & ~w_pop;
    assign w_pcnt_nxt  = r_rise ? '0 : (r_pcnt == P_TO) ? P_TO : r_pcnt + 1'b1;
    // A nominal period sees the count at PERIOD-1 when the next rise arrives.
    assign w_perr_set  = r_armed & ((r_rise & (r_pcnt != P_LAST)) | (w_pcnt_nxt == P_TO));

    assign o_out_valid  = ~w_empty;
    assign o_cpu_rise   = r_rise;
    assign o_cpu_fall   = r_fall;
    assign o_overflow   = r_ovf;
    assign o_period_err = r_perr;

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_hist  <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_pcnt  <= '0;
            r_armed <= 1'b0;
            r_ovf   <= 1'b0;
            r_perr  <= 1'b0;
        end else begin
            r_sync1 <= i_cpu_clk;
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
            r_rise  <= r_sync2 & ~r_hist;
            r_fall  <= ~r_sync2 & r_hist;
            r_pcnt  <= w_pcnt_nxt;
            r_armed <= r_armed | r_rise;
            r_ovf   <= w_ovf_set | (r_ovf & ~i_clr_err);
            r_perr  <= w_perr_set | (r_perr & ~i_clr_err);
        end
    end

    pipeline_clk_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .sysclk      (sysclk),
        .reset       (reset),
        .i_push      (w_push),
        .i_push_data (i_cpu_wr_data),
        .i_pop       (w_pop),
        .o_head      (o_out_data),
        .o_empty     (w_empty),
        .o_full      (w_full)
    );

endmodule

// File: tb/tb_pipeline_clk_bridge.sv
// tb_pipeline_clk_bridge: directed and random CPU traffic against a queue-based reference
module tb_pipeline_clk_bridge;

    localparam int DEPTH  = 4;
    localparam int PERIOD = 18;

    logic        sysclk = 1'b0;
    logic        reset;
    logic        i_cpu_clk;
    logic        i_cpu_wr_en;
    logic [31:0] i_cpu_wr_data;
    logic        o_out_valid;
    logic [31:0] o_out_data;
    logic        i_out_ready;
    logic        o_cpu_rise;
    logic        o_cpu_fall;
    logic        o_overflow;
    logic        o_period_err;
    logic        i_clr_err;

    int ntests = 0;
    int nfail  = 0;
    int nrise  = 0;
    int nfall  = 0;
    logic [31:0] popped[$];

    // Reference: cpu_clk samples per sysclk edge, FIFO as a queue, period as edge timestamps.
    bit          h[8192];
    int          cyc = 3;
    logic [31:0] q[$];
    bit          e_rise, e_fall, e_ovf, e_perr, armed;
    int          last_rise;
    bit          m_pop, m_push, ovf_set, perr_set;

    pipeline_clk_bridge dut (
        .sysclk        (sysclk),
        .reset         (reset),
        .i_cpu_clk     (i_cpu_clk),
        .i_cpu_wr_en   (i_cpu_wr_en),
        .i_cpu_wr_data (i_cpu_wr_data),
        .o_out_valid   (o_out_valid),
        .o_out_data    (o_out_data),
        .i_out_ready   (i_out_ready),
        .o_cpu_rise    (o_cpu_rise),
        .o_cpu_fall    (o_cpu_fall),
        .o_overflow    (o_overflow),
        .o_period_err  (o_period_err),
        .i_clr_err     (i_clr_err)
    );

    always #5 sysclk = ~sysclk;

    always @(posedge sysclk) begin
        cyc++;
        if (cyc > 8190) $fatal(1, "FAIL cycle_budget: observed %0d expected below 8190", cyc);
        if (reset) begin
            h[cyc] = 1'b0;
            q.delete();
            e_rise = 0;
            e_fall = 0;
            e_ovf  = 0;
            e_perr = 0;
            armed  = 0;
        end else begin
            h[cyc]  = i_cpu_clk;
            m_pop   = q.size() > 0 && i_out_ready;
            m_push  = e_fall && i_cpu_wr_en;
            ovf_set = 0;
            if (m_pop) void'(q.pop_front());
            if (m_push) begin
                if (q.size() < DEPTH) q.push_back(i_cpu_wr_data);
                else ovf_set = 1;
            end
            perr_set = 0;
            if (e_rise) begin
                if (armed && cyc - last_rise != PERIOD) perr_set = 1;
                armed     = 1;
                last_rise = cyc;
            end else if (armed && cyc - last_rise >= 2 * PERIOD) perr_set = 1;
            e_ovf  = ovf_set | (e_ovf & ~i_clr_err);
            e_perr = perr_set | (e_perr & ~i_clr_err);
            // A level change becomes visible as a strobe three edges later.
            e_rise = h[cyc-2] & ~h[cyc-3];
            e_fall = ~h[cyc-2] & h[cyc-3];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        if (o_out_valid && i_out_ready) popped.push_back(o_out_data);
        @(posedge sysclk);
        #1;
        if (!reset) begin
            chk("rise", o_cpu_rise, e_rise);
            chk("fall", o_cpu_fall, e_fall);
            chk("valid", o_out_valid, q.size() > 0);
            chk("overflow", o_overflow, e_ovf);
            chk("period_err", o_period_err, e_perr);
            if (q.size() > 0) chk("data", o_out_data, q[0]);
            nrise += int'(o_cpu_rise);
            nfall += int'(o_cpu_fall);
        end
    endtask

    // mode 0: leave out_ready alone, 1: pulse it on the fall-strobe cycle, 2: random each cycle
    task automatic cpu_cycle(input int hi, input int lo, input bit wr, input logic [31:0] d, input int mode);
        i_cpu_clk     = 1'b1;
        i_cpu_wr_en   = wr;
        i_cpu_wr_data = d;
        for (int t = 1; t <= hi + lo; t++) begin
            tick();
            if (t == 1) i_clr_err = 1'b0;
            if (t == hi) i_cpu_clk = 1'b0;
            if (mode == 1) i_out_ready = (t == hi + 3);
            if (mode == 2) i_out_ready = 1'($urandom_range(0, 1));
        end
    endtask

    initial begin
        reset = 1'b1;
        i_cpu_clk = 1'b0;
        i_cpu_wr_en = 1'b0;
        i_cpu_wr_data = '0;
        i_out_ready = 1'b0;
        i_clr_err = 1'b0;
        tick();
        chk("reset_valid", o_out_valid, 0);
        chk("reset_ovf", o_overflow, 0);
        chk("reset_perr", o_period_err, 0);
        chk("reset_rise", o_cpu_rise, 0);
        repeat (4) tick();
        reset = 1'b0;

        nrise = 0;
        nfall = 0;
        for (int i = 0; i < 10; i++) cpu_cycle(9, 9, 0, 0, 0);
        chk("rise_count", nrise, 10);
        chk("fall_count", nfall, 10);
        chk("idle_perr", o_period_err, 0);
        chk("idle_valid", o_out_valid, 0);

        i_out_ready = 1'b1;
        popped.delete();
        cpu_cycle(9, 9, 1, 32'h11111111, 0);
        cpu_cycle(9, 9, 1, 32'h22222222, 0);
        cpu_cycle(9, 9, 1, 32'h33333333, 0);
        cpu_cycle(9, 9, 0, 0, 0);
        chk("seq_count", popped.size(), 3);
        chk("seq_0", popped[0], 32'h11111111);
        chk("seq_1", popped[1], 32'h22222222);
        chk("seq_2", popped[2], 32'h33333333);

        i_out_ready = 1'b0;
        for (int i = 0; i < 5; i++) cpu_cycle(9, 9, 1, 32'hA0 + i, 0);
        chk("ovf_set", o_overflow, 1);
        chk("full_valid", o_out_valid, 1);
        popped.delete();
        i_out_ready = 1'b1;
        cpu_cycle(9, 9, 0, 0, 0);
        chk("drain_count", popped.size(), 4);
        for (int i = 0; i < 4; i++) chk("drain_data", popped[i], 32'hA0 + i);
        chk("drain_empty", o_out_valid, 0);
        i_out_ready = 1'b0;
        i_clr_err = 1'b1;
        cpu_cycle(9, 9, 0, 0, 0);
        chk("ovf_clr", o_overflow, 0);

        for (int i = 0; i < 4; i++) cpu_cycle(9, 9, 1, $urandom, 0);
        cpu_cycle(9, 9, 1, 32'hB0, 1);
        chk("pushpop_ovf", o_overflow, 0);
        popped.delete();
        i_out_ready = 1'b1;
        cpu_cycle(9, 9, 0, 0, 0);
        chk("pushpop_count", popped.size(), 4);
        chk("pushpop_last", popped[3], 32'hB0);

        for (int i = 0; i < 20; i++) cpu_cycle(9, 9, 1'($urandom_range(0, 1)), $urandom, 2);

        i_out_ready = 1'b1;
        i_clr_err = 1'b1;
        cpu_cycle(9, 9, 0, 0, 0);
        cpu_cycle(9, 9, 0, 0, 0);
        chk("pre_stretch_perr", o_period_err, 0);
        cpu_cycle(11, 9, 0, 0, 0);
        cpu_cycle(9, 9, 0, 0, 0);
        chk("stretch_perr", o_period_err, 1);
        i_clr_err = 1'b1;
        cpu_cycle(9, 9, 0, 0, 0);
        chk("perr_clr", o_period_err, 0);

        i_out_ready = 1'b0;
        i_cpu_wr_en = 1'b0;
        repeat (21) tick();
        chk("stop_early", o_period_err, 0);
        tick();
        chk("stop_timeout", o_period_err, 1);

        i_clr_err = 1'b1;
        for (int i = 0; i < 3; i++) cpu_cycle(9, 9, 1, $urandom, 0);
        chk("restart_perr", o_period_err, 1);
        chk("queued_valid", o_out_valid, 1);
        reset = 1'b1;
        #1;
        chk("async_valid", o_out_valid, 0);
        chk("async_ovf", o_overflow, 0);
        chk("async_perr", o_period_err, 0);
        i_cpu_clk = 1'b0;
        repeat (4) tick();
        reset = 1'b0;
        repeat (5) tick();
        for (int i = 0; i < 3; i++) cpu_cycle(9, 9, 0, 0, 0);
        chk("post_reset_perr", o_period_err, 0);
        chk("post_reset_valid", o_out_valid, 0);

        for (int i = 0; i < 15; i++) cpu_cycle(9, 9, 1'($urandom_range(0, 1)), $urandom, 2);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
